// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and helpers
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OSR       = 16;
  localparam int DATA_BITS = 8;

  localparam logic [3:0] SMP_LO  = 4'd7;
  localparam logic [3:0] SMP_MID = 4'd8;
  localparam logic [3:0] SMP_HI  = 4'd9;

  // Two-of-three vote over the samples taken around mid-bit.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample tick divider with phase clear
module baud_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider; clr restarts the phase so ticks line up with a start edge.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with 16x oversampling and majority vote
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int RAW_DIV  = CLK_FREQ / (BAUD * OSR);
  localparam int TICK_DIV = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int BCW      = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic                 rxd_m, rxd_s;
  logic                 tick;
  logic [3:0]           scnt_q;
  logic [BCW-1:0]       bitcnt_q;
  logic [2:0]           smp_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 armed_q;

  logic start_go, decide, wrap, maj;
  logic deliver, fe_set, ovr_set;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .clr    (start_go),
    .tick   (tick)
  );

  // Next-state and event decode; bit decisions happen on the tick where scnt becomes 10.
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    decide   = tick && (scnt_q == SMP_HI);
    wrap     = tick && (scnt_q == 4'(OSR - 1));
    maj      = majority3(smp_q);
    deliver  = 1'b0;
    fe_set   = 1'b0;
    ovr_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s && armed_q) begin
          start_go = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (wrap && (bitcnt_q == BCW'(DATA_BITS - 1))) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          state_d = IDLE;
          deliver = maj;
          fe_set  = !maj;
          ovr_set = maj && rx_valid && !rx_ack;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample counter, mid-bit samples, bit counter, shifter and break re-arm.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      scnt_q   <= '0;
      smp_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (start_go) begin
        scnt_q <= '0;
      end else if (tick) begin
        scnt_q <= scnt_q + 4'd1;
      end
      if (tick && (scnt_q == SMP_LO - 4'd1))  smp_q[0] <= rxd_s;
      if (tick && (scnt_q == SMP_MID - 4'd1)) smp_q[1] <= rxd_s;
      if (tick && (scnt_q == SMP_HI - 4'd1))  smp_q[2] <= rxd_s;
      if ((state_q == START) && wrap) begin
        bitcnt_q <= '0;
      end else if ((state_q == DATA) && wrap) begin
        bitcnt_q <= bitcnt_q + BCW'(1);
      end
      if ((state_q == DATA) && decide) begin
        shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
      end
      if (fe_set) begin
        armed_q <= 1'b0;
      end else if ((state_q == IDLE) && rxd_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Output holding register and sticky flags; a set in the same cycle beats an ack clear.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shreg_q;
          rx_valid <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (rx_ack) begin
        overrun <= 1'b0;
      end
      if (fe_set) begin
        frame_err <= 1'b1;
      end else if (rx_ack) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
